spi_controller: RTL and testbench

SPI mode-0 initiator that drives the 16-bit register-write frames consumed by the chip's SPI register peripheral (en_reg_out, en_reg_pwm, pwm_duty_cycle). Frame = {rw, addr[6:0], data[7:0]}, MSB first, one frame per nCS-low window. Used by a test harness or on-chip sequencer to program the peripheral. SCLK is generated from clk by a programmable divider, slow enough for the peripheral's 2-flop synchronisers.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_phase_timer.sv | 39 +++
 rtl/spi_controller.sv | 164 ++++++++++++++++
 tb/tb_spi_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI register-write controller.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_HOLD,
    ST_GAP
  } spi_ctrl_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter: after a load of N-1 it raises expire on the Nth cycle, once.
module spi_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = load_val;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) armed_d = 1'b0;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire = armed_q && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator sending 16-bit {rw, addr, data} frames MSB first.
// Optional read-back capture on cipo is enabled by defining SPI_CIPO_READ_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              tx_rw,
  input  logic [ADDR_W-1:0] tx_addr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ncs,
  output logic              copi
`ifdef SPI_CIPO_READ_EN
  ,
  input  logic              cipo,
  output logic [DATA_W-1:0] rx_data
`endif
);

  localparam int TMR_W = $clog2(max_int(CLK_DIV, GAP_CYCLES) + 1);

  spi_ctrl_state_t      state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 ncs_q, ncs_d;
  logic                 copi_q, copi_d;
  logic                 done_q, done_d;
  logic                 tmr_load, tmr_expire;
  logic [TMR_W-1:0]     tmr_val;
`ifdef SPI_CIPO_READ_EN
  logic                 rw_q, rw_d;
  logic [DATA_W-1:0]    rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
`endif

  spi_phase_timer #(.WIDTH(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = TMR_W'(CLK_DIV - 1);
`ifdef SPI_CIPO_READ_EN
    rw_d       = rw_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d   = {tx_rw, tx_addr, tx_data};
          bit_cnt_d = '0;
          state_d   = ST_LOW;
          tmr_load  = 1'b1;
`ifdef SPI_CIPO_READ_EN
          rw_d = tx_rw;
`endif
        end
      end
      ST_LOW: begin
        if (tmr_expire) begin
          state_d  = ST_HIGH;
          tmr_load = 1'b1;
`ifdef SPI_CIPO_READ_EN
          rx_shift_d = {rx_shift_q[DATA_W-2:0], cipo};
`endif
        end
      end
      ST_HIGH: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bit_cnt_q != 4'd15) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            state_d   = ST_LOW;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_expire) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES - 1);
          done_d   = 1'b1;
`ifdef SPI_CIPO_READ_EN
          if (rw_q != RW_WRITE) rx_data_d = rx_shift_q;
`endif
        end
      end
      ST_GAP: begin
        if (tmr_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin values are registered from the next state so they change cleanly on clk.
    sclk_d = (state_d == ST_HIGH);
    ncs_d  = !((state_d == ST_LOW) || (state_d == ST_HIGH) || (state_d == ST_HOLD));
    copi_d = ncs_d ? 1'b0 : shift_d[FRAME_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      ncs_q     <= 1'b1;
      copi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      ncs_q     <= ncs_d;
      copi_q    <= copi_d;
      done_q    <= done_d;
    end
  end

`ifdef SPI_CIPO_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q       <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      rw_q       <= rw_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_data = rx_data_q;
`endif

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = !tx_ready;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign ncs      = ncs_q;
  assign copi     = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: one DUT at CLK_DIV=4 and one at CLK_DIV=2, both GAP_CYCLES=4.
module tb_spi_controller;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid [2];
  logic       tx_rw    [2];
  logic [6:0] tx_addr  [2];
  logic [7:0] tx_data  [2];
  logic       tx_ready [2];
  logic       busy     [2];
  logic       done     [2];
  logic       sclk     [2];
  logic       ncs      [2];
  logic       copi     [2];
`ifdef SPI_CIPO_READ_EN
  logic        cipo    [2];
  logic [7:0]  rx_data [2];
  logic [15:0] cipo_pat = 16'h0000;
`endif

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_rw(tx_rw[0]),
    .tx_addr(tx_addr[0]), .tx_data(tx_data[0]), .busy(busy[0]), .done(done[0]),
    .sclk(sclk[0]), .ncs(ncs[0]), .copi(copi[0])
`ifdef SPI_CIPO_READ_EN
    , .cipo(cipo[0]), .rx_data(rx_data[0])
`endif
  );

  spi_controller #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_rw(tx_rw[1]),
    .tx_addr(tx_addr[1]), .tx_data(tx_data[1]), .busy(busy[1]), .done(done[1]),
    .sclk(sclk[1]), .ncs(ncs[1]), .copi(copi[1])
`ifdef SPI_CIPO_READ_EN
    , .cipo(cipo[1]), .rx_data(rx_data[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  // Bus monitor state, sampled on the falling clock edge.
  int          cyc = 0;
  int          acc_cyc [2]    = '{default: 0};
  int          acc_cnt [2]    = '{default: 0};
  int          done_cyc [2]   = '{default: 0};
  int          done_cnt [2]   = '{default: 0};
  int          ready_cyc [2]  = '{default: 0};
  int          rises [2]      = '{default: 0};
  int          low_run [2]    = '{default: 0};
  int          high_run [2]   = '{default: 0};
  int          last_low [2]   = '{default: 0};
  int          last_high [2]  = '{default: 0};
  int          last_rises [2] = '{default: 0};
  int          phase_run [2]  = '{default: 0};
  int          phase_err [2]  = '{default: 0};
  int          unstable [2]   = '{default: 0};
  int          stray_edge [2] = '{default: 0};
  int          both_err [2]   = '{default: 0};
  logic [15:0] cap [2]        = '{default: 16'h0};
  logic [15:0] last_cap [2]   = '{default: 16'h0};
  logic        prev_sclk [2]  = '{default: 1'b0};
  logic        prev_ncs [2]   = '{default: 1'b1};
  logic        prev_copi [2]  = '{default: 1'b0};
  logic        prev_ready [2] = '{default: 1'b0};
  logic [7:0]  preg [128]     = '{default: 8'h00};

`ifdef SPI_CIPO_READ_EN
  // Present cipo bit (15 - rises) during each low phase so the rise samples it.
  assign cipo[0] = (rises[0] < 16) ? cipo_pat[15 - rises[0]] : 1'b0;
  assign cipo[1] = (rises[1] < 16) ? cipo_pat[15 - rises[1]] : 1'b0;
`endif

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (tx_valid[i] && tx_ready[i]) begin acc_cyc[i] = cyc; acc_cnt[i]++; end
      if (done[i]) begin
        done_cyc[i] = cyc;
        done_cnt[i]++;
        if (tx_ready[i]) both_err[i]++;
      end
      if (tx_ready[i] && !prev_ready[i]) ready_cyc[i] = cyc;
      if (!ncs[i]) begin
        if (prev_ncs[i]) begin
          last_high[i] = high_run[i];
          low_run[i] = 0; rises[i] = 0; cap[i] = 16'h0; phase_run[i] = 0;
        end
        low_run[i]++;
        if (sclk[i] != prev_sclk[i] && !prev_ncs[i]) begin
          if (phase_run[i] != ((i == 0) ? 4 : 2)) phase_err[i]++;
          phase_run[i] = 0;
        end
        phase_run[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          cap[i] = {cap[i][14:0], copi[i]};
          rises[i]++;
          if (copi[i] != prev_copi[i]) unstable[i]++;
        end
      end else begin
        if (!prev_ncs[i]) begin
          last_low[i] = low_run[i]; last_rises[i] = rises[i]; last_cap[i] = cap[i];
          high_run[i] = 0;
          if (i == 0 && rises[i] == 16 && cap[i][15] == RW_WRITE) preg[cap[i][14:8]] = cap[i][7:0];
        end
        high_run[i]++;
        if (sclk[i]) stray_edge[i]++;
      end
      prev_sclk[i] = sclk[i]; prev_ncs[i] = ncs[i]; prev_copi[i] = copi[i]; prev_ready[i] = tx_ready[i];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [15:0] f);
    tx_rw[i] = f[15]; tx_addr[i] = f[14:8]; tx_data[i] = f[7:0];
  endtask

  task automatic accept(input int i, input logic [15:0] f);
    int a0;
    a0 = acc_cnt[i];
    drive(i, f);
    tx_valid[i] = 1'b1;
    for (int k = 0; k < 3000 && acc_cnt[i] == a0; k++) tick();
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n0);
    for (int k = 0; k < 3000 && done_cnt[i] <= n0; k++) tick();
  endtask

  task automatic wait_ready(input int i);
    for (int k = 0; k < 3000 && !(tx_ready[i] && ready_cyc[i] > done_cyc[i]); k++) tick();
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
    checks++; if ({ncs[0], sclk[0], copi[0], done[0]} !== 4'b1000) begin errors++; $display("FAIL reset_pins got=%b exp=1000", {ncs[0], sclk[0], copi[0], done[0]}); end
`ifdef SPI_CIPO_READ_EN
    checks++; if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%0h exp=0", rx_data[0]); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write;
    int d0;
    d0 = done_cnt[0];
    accept(0, 16'h8480);
    wait_done(0, d0);
    wait_ready(0);
    $display("write frame 8480: cap=%04h rises=%0d low=%0d", last_cap[0], last_rises[0], last_low[0]);
    checks++; if (done_cnt[0] - d0 !== 1) begin errors++; $display("FAIL write_done_count got=%0d exp=1", done_cnt[0] - d0); end
    checks++; if (last_cap[0] !== 16'h8480) begin errors++; $display("FAIL write_copi got=%04h exp=8480", last_cap[0]); end
    checks++; if (last_rises[0] !== 16) begin errors++; $display("FAIL write_rises got=%0d exp=16", last_rises[0]); end
    checks++; if (last_low[0] !== 132) begin errors++; $display("FAIL write_ncs_low got=%0d exp=132", last_low[0]); end
    checks++; if (done_cyc[0] - acc_cyc[0] !== 133) begin errors++; $display("FAIL write_acc_to_done got=%0d exp=133", done_cyc[0] - acc_cyc[0]); end
    checks++; if (ready_cyc[0] - done_cyc[0] !== 4) begin errors++; $display("FAIL write_done_to_ready got=%0d exp=4", ready_cyc[0] - done_cyc[0]); end
    checks++; if (phase_err[0] !== 0) begin errors++; $display("FAIL write_phase_len got=%0d exp=0", phase_err[0]); end
  endtask

  task automatic test_back_to_back;
    int a0, d0;
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    drive(0, 16'h81AA);
    tx_valid[0] = 1'b1;
    for (int k = 0; k < 3000 && acc_cnt[0] == a0; k++) tick();
    drive(0, 16'h8255);
    for (int k = 0; k < 3000 && acc_cnt[0] < a0 + 2; k++) tick();
    tx_valid[0] = 1'b0;
    checks++; if (last_cap[0] !== 16'h81AA || last_rises[0] !== 16) begin errors++; $display("FAIL b2b_frame1 got=%04h/%0d exp=81aa/16", last_cap[0], last_rises[0]); end
    wait_done(0, d0 + 1);
    wait_ready(0);
    $display("back-to-back: cap=%04h gap=%0d reg1=%02h reg2=%02h", last_cap[0], last_high[0], preg[1], preg[2]);
    checks++; if (last_cap[0] !== 16'h8255 || last_rises[0] !== 16) begin errors++; $display("FAIL b2b_frame2 got=%04h/%0d exp=8255/16", last_cap[0], last_rises[0]); end
    checks++; if (last_high[0] !== 5) begin errors++; $display("FAIL b2b_ncs_gap got=%0d exp=5", last_high[0]); end
    checks++; if (preg[REG_EN_OUT_15_8] !== 8'hAA) begin errors++; $display("FAIL b2b_en_out_15_8 got=%02h exp=aa", preg[REG_EN_OUT_15_8]); end
    checks++; if (preg[REG_EN_PWM_7_0] !== 8'h55) begin errors++; $display("FAIL b2b_en_pwm_7_0 got=%02h exp=55", preg[REG_EN_PWM_7_0]); end
  endtask

  task automatic test_ignore_busy;
    int a0, d0;
    a0 = acc_cnt[0];
    d0 = done_cnt[0];
    drive(0, 16'h8122);
    tx_valid[0] = 1'b1;
    for (int k = 0; k < 3000 && acc_cnt[0] == a0; k++) tick();
    repeat (20) tick();
    drive(0, 16'h7FEE);
    wait_done(0, d0);
    $display("ignore busy: cap=%04h accepts=%0d", last_cap[0], acc_cnt[0] - a0);
    checks++; if (acc_cnt[0] - a0 !== 1) begin errors++; $display("FAIL busy_accepts got=%0d exp=1", acc_cnt[0] - a0); end
    checks++; if (last_cap[0] !== 16'h8122) begin errors++; $display("FAIL busy_latched got=%04h exp=8122", last_cap[0]); end
    tx_valid[0] = 1'b0;
    wait_ready(0);
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt[0];
    drive(0, 16'h8011);
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    for (int k = 0; k < 3000 && rises[0] < 7; k++) tick();
    rst = 1'b1;
    #1;
    $display("reset mid-frame after %0d rises: ncs=%b sclk=%b", rises[0], ncs[0], sclk[0]);
    checks++; if ({ncs[0], sclk[0]} !== 2'b10) begin errors++; $display("FAIL midrst_pins got=%b exp=10", {ncs[0], sclk[0]}); end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (tx_ready[0] !== 1'b1 || done_cnt[0] !== d0) begin errors++; $display("FAIL midrst_after got=%b/%0d exp=1/%0d", tx_ready[0], done_cnt[0], d0); end
    accept(0, 16'h8433);
    wait_done(0, d0);
    $display("post-reset frame: cap=%04h rises=%0d", last_cap[0], last_rises[0]);
    checks++; if (last_cap[0] !== 16'h8433 || last_rises[0] !== 16) begin errors++; $display("FAIL midrst_next got=%04h/%0d exp=8433/16", last_cap[0], last_rises[0]); end
    wait_ready(0);
  endtask

  task automatic test_clkdiv2;
    int d0;
    d0 = done_cnt[1];
    accept(1, 16'h80FF);
    wait_done(1, d0);
    wait_ready(1);
    $display("clkdiv2 frame 80ff: cap=%04h low=%0d", last_cap[1], last_low[1]);
    checks++; if (last_cap[1] !== 16'h80FF || last_rises[1] !== 16) begin errors++; $display("FAIL div2_copi got=%04h/%0d exp=80ff/16", last_cap[1], last_rises[1]); end
    checks++; if (last_low[1] !== 66) begin errors++; $display("FAIL div2_ncs_low got=%0d exp=66", last_low[1]); end
    checks++; if (done_cyc[1] - acc_cyc[1] !== 67) begin errors++; $display("FAIL div2_acc_to_done got=%0d exp=67", done_cyc[1] - acc_cyc[1]); end
    checks++; if (phase_err[1] !== 0) begin errors++; $display("FAIL div2_phase_len got=%0d exp=0", phase_err[1]); end
    checks++; if (unstable[1] !== 0 || unstable[0] !== 0) begin errors++; $display("FAIL copi_stable got=%0d/%0d exp=0/0", unstable[0], unstable[1]); end
    checks++; if (stray_edge[0] !== 0 || stray_edge[1] !== 0) begin errors++; $display("FAIL sclk_while_ncs_high got=%0d/%0d exp=0/0", stray_edge[0], stray_edge[1]); end
    checks++; if (both_err[0] !== 0 || both_err[1] !== 0) begin errors++; $display("FAIL done_with_ready got=%0d/%0d exp=0/0", both_err[0], both_err[1]); end
  endtask

`ifdef SPI_CIPO_READ_EN
  task automatic test_read;
    int d0;
    d0 = done_cnt[0];
    cipo_pat = 16'h003C;
    accept(0, 16'h0400);
    wait_done(0, d0);
    $display("read frame 0400: rx_data=%02h", rx_data[0]);
    checks++; if (rx_data[0] !== 8'h3C) begin errors++; $display("FAIL read_rx_data got=%02h exp=3c", rx_data[0]); end
    wait_ready(0);
    cipo_pat = 16'hFFFF;
    accept(0, 16'h8411);
    wait_done(0, d0 + 1);
    $display("write after read: rx_data=%02h", rx_data[0]);
    checks++; if (rx_data[0] !== 8'h3C) begin errors++; $display("FAIL read_hold got=%02h exp=3c", rx_data[0]); end
    wait_ready(0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 2; i++) begin
      tx_valid[i] = 1'b0; tx_rw[i] = 1'b0; tx_addr[i] = 7'h00; tx_data[i] = 8'h00;
    end
    test_reset();
    test_write();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_clkdiv2();
`ifdef SPI_CIPO_READ_EN
    test_read();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
